// File: rtl/el_pkg.sv
// el_pkg: dual-rail encoding constants, FSM state types and single-bit
// encode/decode helpers for the elastic adder host.
package el_pkg;

    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ILL  = 2'b11;

    typedef enum logic [1:0] {T_IDLE, T_DATA, T_NULL} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_NULL, R_OUT} rx_state_e;

    function automatic logic [1:0] dr_encode(input logic b);
        return b ? DR_ONE : DR_ZERO;
    endfunction

    // DR_ILL is deliberately not valid so it never completes a word
    function automatic logic dr_valid(input logic [1:0] r);
        return (r == DR_ZERO) || (r == DR_ONE);
    endfunction

    function automatic logic dr_decode(input logic [1:0] r);
        return r == DR_ONE;
    endfunction

endpackage

// File: rtl/el_sync_flag.sv
// el_sync_flag: STAGES-deep single-bit synchroniser with async active-low reset.
module el_sync_flag #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("el_sync_flag: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d_i};

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/el_adder_host.sv
// el_adder_host: valid/ready host driving dual-rail four-phase adder links.
// Define EL_HOST_TIMEOUT_EN to add the per-phase watchdog and sticky err_o.
module el_adder_host
    import el_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int RAIL_NUM       = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_valid_i,
    output logic                      op_ready_o,
    input  logic [WIDTH-1:0]          op_a_i,
    input  logic [WIDTH-1:0]          op_b_i,
    input  logic                      op_c_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [WIDTH-1:0]          res_s_o,
    output logic                      res_c_o,
    output logic [RAIL_NUM*WIDTH-1:0] out_a,
    input  logic [WIDTH-1:0]          ack_a_i,
    output logic [RAIL_NUM*WIDTH-1:0] out_b,
    input  logic [WIDTH-1:0]          ack_b_i,
    output logic [RAIL_NUM-1:0]       out_c,
    input  logic                      ack_c_i,
    input  logic [RAIL_NUM*WIDTH-1:0] in_s,
    output logic [WIDTH-1:0]          ack_s_o,
    input  logic [RAIL_NUM-1:0]       in_co,
    output logic                      ack_co_o,
    output logic                      err_o
);

    if (RAIL_NUM != 2) begin : g_bad_rails
        $error("el_adder_host: only RAIL_NUM == 2 is supported");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("el_adder_host: TIMEOUT_CYCLES must be positive");
    end

    tx_state_e tx_q, tx_d;
    rx_state_e rx_q, rx_d;
    logic [RAIL_NUM*WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d, enc_a, enc_b;
    logic [RAIL_NUM-1:0] out_c_q, out_c_d;
    logic [WIDTH-1:0] s_q, s_d, dec_s, bit_ok;
    logic co_q, co_d, ack_q, ack_d, valid_q, valid_d, rdy_q, rdy_d;
    logic accept, tmo;
    logic ack_hi, ack_lo, data_done, null_done;
    logic ack_hi_s, ack_lo_s, data_s, null_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign enc_a[RAIL_NUM*i +: 2] = dr_encode(op_a_i[i]);
        assign enc_b[RAIL_NUM*i +: 2] = dr_encode(op_b_i[i]);
        assign dec_s[i]  = dr_decode(in_s[RAIL_NUM*i +: 2]);
        assign bit_ok[i] = dr_valid(in_s[RAIL_NUM*i +: 2]);
    end

    // Only these four reduced flags cross into the clock domain
    assign ack_hi    = (&ack_a_i) & (&ack_b_i) & ack_c_i;
    assign ack_lo    = ~((|ack_a_i) | (|ack_b_i) | ack_c_i);
    assign data_done = (&bit_ok) & dr_valid(in_co);
    assign null_done = ~(|in_s) & ~(|in_co);

    el_sync_flag #(.STAGES(SYNC_STAGES)) u_sync_ack_hi (.clk(clk), .rst_n(rst), .d_i(ack_hi),    .q_o(ack_hi_s));
    el_sync_flag #(.STAGES(SYNC_STAGES)) u_sync_ack_lo (.clk(clk), .rst_n(rst), .d_i(ack_lo),    .q_o(ack_lo_s));
    el_sync_flag #(.STAGES(SYNC_STAGES)) u_sync_data   (.clk(clk), .rst_n(rst), .d_i(data_done), .q_o(data_s));
    el_sync_flag #(.STAGES(SYNC_STAGES)) u_sync_null   (.clk(clk), .rst_n(rst), .d_i(null_done), .q_o(null_s));

`ifdef EL_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;
    logic err_q, rx_busy;

    assign rx_busy = (rx_q == R_WAIT) || (rx_q == R_NULL);
    assign tmo = ((tx_q != T_IDLE) && (tx_cnt_q == CW'(TIMEOUT_CYCLES - 1))) ||
                 (rx_busy && (rx_cnt_q == CW'(TIMEOUT_CYCLES - 1)));
    assign err_o = err_q;

    // Each counter restarts whenever its FSM changes phase
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tx_cnt_q <= (tmo || tx_d != tx_q || tx_q == T_IDLE) ? '0 : tx_cnt_q + CW'(1);
            rx_cnt_q <= (tmo || rx_d != rx_q || !rx_busy) ? '0 : rx_cnt_q + CW'(1);
            err_q    <= err_q | tmo;
        end
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    assign accept = op_valid_i && rdy_q;

    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        out_c_d = out_c_q;
        s_d     = s_q;
        co_d    = co_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        case (tx_q)
            T_IDLE: if (accept) begin
                tx_d    = T_DATA;
                out_a_d = enc_a;
                out_b_d = enc_b;
                out_c_d = dr_encode(op_c_i);
            end
            T_DATA: if (ack_hi_s) begin
                tx_d    = T_NULL;
                out_a_d = '0;
                out_b_d = '0;
                out_c_d = DR_NULL;
            end
            T_NULL:  tx_d = ack_lo_s ? T_IDLE : T_NULL;
            default: tx_d = T_IDLE;
        endcase
        case (rx_q)
            R_IDLE: rx_d = accept ? R_WAIT : R_IDLE;
            R_WAIT: if (data_s) begin
                rx_d  = R_NULL;
                s_d   = dec_s;
                co_d  = dr_decode(in_co);
                ack_d = 1'b1;
            end
            R_NULL: if (null_s) begin
                rx_d    = R_OUT;
                ack_d   = 1'b0;
                valid_d = 1'b1;
            end
            R_OUT: if (res_ready_i) begin
                rx_d    = R_IDLE;
                valid_d = 1'b0;
            end
            default: rx_d = R_IDLE;
        endcase
        if (tmo) begin
            tx_d    = T_IDLE;
            rx_d    = R_IDLE;
            out_a_d = '0;
            out_b_d = '0;
            out_c_d = DR_NULL;
            ack_d   = 1'b0;
            valid_d = 1'b0;
        end
        rdy_d = (tx_d == T_IDLE) && (rx_d == R_IDLE) && !valid_d;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tx_q    <= T_IDLE;
            rx_q    <= R_IDLE;
            out_a_q <= '0;
            out_b_q <= '0;
            out_c_q <= DR_NULL;
            s_q     <= '0;
            co_q    <= 1'b0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            out_c_q <= out_c_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
        end

    assign op_ready_o  = rdy_q;
    assign res_valid_o = valid_q;
    assign res_s_o     = s_q;
    assign res_c_o     = co_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_c       = out_c_q;
    assign ack_s_o     = {WIDTH{ack_q}};
    assign ack_co_o    = ack_q;

endmodule

// File: tb/tb_el_adder_host.sv
// tb_el_adder_host: directed vectors against a behavioural four-phase dual-rail adder.
module tb_el_adder_host;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic op_valid_i = 1'b0, op_c_i = 1'b0, res_ready_i = 1'b0;
    logic [W-1:0] op_a_i = '0, op_b_i = '0;
    logic op_ready_o, res_valid_o, res_c_o, ack_co_o, err_o;
    logic [W-1:0] res_s_o, ack_s_o;
    logic [2*W-1:0] out_a, out_b, in_s;
    logic [1:0] out_c, in_co;
    logic [W-1:0] ack_a_i, ack_b_i;
    logic ack_c_i;

    always #5 clk = ~clk;

    el_adder_host #(.WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_s_o(res_s_o), .res_c_o(res_c_o),
        .out_a(out_a), .ack_a_i(ack_a_i),
        .out_b(out_b), .ack_b_i(ack_b_i),
        .out_c(out_c), .ack_c_i(ack_c_i),
        .in_s(in_s), .ack_s_o(ack_s_o),
        .in_co(in_co), .ack_co_o(ack_co_o),
        .err_o(err_o)
    );

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [W-1:0] dec(input logic [2*W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[2*i+1];
        return r;
    endfunction

    function automatic bit all_data(input logic [2*W-1:0] x);
        bit ok = 1;
        for (int i = 0; i < W; i++) ok &= ^x[2*i +: 2];
        return ok;
    endfunction

    // Environment controls, written only by the stimulus process
    bit hold_c = 0;
    int dly_bit = -1;
    int dly_n = 0;

    // Behavioural adder: acks inputs as they turn data/spacer, produces sum
    always begin : adder_model
        int data_cycles;
        logic [W:0] sum;
        @(posedge clk or negedge rst);
        if (!rst) begin
            ack_a_i = '0; ack_b_i = '0; ack_c_i = 1'b0;
            in_s = '0; in_co = 2'b00; data_cycles = 0;
        end else begin
            #3;
            data_cycles = (out_a == '0) ? 0 : data_cycles + 1;
            for (int i = 0; i < W; i++) begin
                if (out_a[2*i +: 2] == 2'b00) ack_a_i[i] = 1'b0;
                else if (^out_a[2*i +: 2] && !(i == dly_bit && data_cycles < dly_n)) ack_a_i[i] = 1'b1;
                if (out_b[2*i +: 2] == 2'b00) ack_b_i[i] = 1'b0;
                else if (^out_b[2*i +: 2]) ack_b_i[i] = 1'b1;
            end
            if (out_c == 2'b00) ack_c_i = 1'b0;
            else if (^out_c && !hold_c) ack_c_i = 1'b1;
            if (all_data(out_a) && all_data(out_b) && ^out_c && in_co == 2'b00 && ack_s_o == '0) begin
                sum   = {1'b0, dec(out_a)} + {1'b0, dec(out_b)} + (W+1)'(out_c[1]);
                in_s  = enc(sum[W-1:0]);
                in_co = sum[W] ? 2'b10 : 2'b01;
            end else if (out_a == '0 && out_b == '0 && out_c == 2'b00 && (&ack_s_o) && ack_co_o) begin
                in_s  = '0;
                in_co = 2'b00;
            end
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [W-1:0] r_s;
    logic r_co;
    bit r_to, r_bad, r_leak, r_spc;
    int r_held, r_lat;

    // One operation; during `hold` cycles the result is withheld while the
    // next operand word is already offered
    task automatic run_op(input logic [W-1:0] a, b, input logic c, input int hold,
                          input logic [W-1:0] na, nb, input logic nc);
        int n;
        bit seen_ack, spc;
        logic [2*W-1:0] ea;
        ea = enc(a); r_to = 0; r_bad = 0; r_leak = 0; r_held = 0; seen_ack = 0; spc = 0;
        op_a_i = a; op_b_i = b; op_c_i = c; op_valid_i = 1'b1;
        n = 0;
        while (!op_ready_o && n < 300) begin @(negedge clk); n++; end
        if (!op_ready_o) r_to = 1;
        @(negedge clk);
        op_valid_i = 1'b0;
        n = 1;
        while (!res_valid_o && n < 1000) begin
            if (!spc && out_a != '0) begin
                r_held++;
                if (out_a !== ea) r_bad = 1;
                if (&ack_a_i) seen_ack = 1;
            end else if (!spc) begin
                spc = 1;
                if (!seen_ack) r_bad = 1;
            end
            @(negedge clk);
            n++;
        end
        if (!res_valid_o) r_to = 1;
        r_lat = n;
        r_spc = (out_a == '0) && (out_b == '0) && (out_c == 2'b00);
        r_s = res_s_o;
        r_co = res_c_o;
        if (hold > 0) begin
            op_a_i = na; op_b_i = nb; op_c_i = nc; op_valid_i = 1'b1;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (op_ready_o || out_a != '0 || !res_valid_o || res_s_o !== r_s) r_leak = 1;
        end
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[3] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
        vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vt[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
        vt[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};

        #1;
        chk("reset_op_ready", op_ready_o, 0);
        chk("reset_res_valid", res_valid_o, 0);
        chk("reset_out_a", out_a, 0);
        chk("reset_out_c", out_c, 0);
        chk("reset_ack_s", ack_s_o, 0);
        chk("reset_res_s", res_s_o, 0);
        chk("reset_err", err_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("ready_before_edge", op_ready_o, 0);
        @(posedge clk);
        #1 chk("ready_after_edge", op_ready_o, 1);
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_op(vt[v].a, vt[v].b, vt[v].c, 0, '0, '0, 1'b0);
            chk($sformatf("v%0d_timeout", v), r_to, 0);
            chk($sformatf("v%0d_sum", v), r_s, vt[v].s);
            chk($sformatf("v%0d_cout", v), r_co, vt[v].co);
            chk($sformatf("v%0d_spacer_before_valid", v), r_spc, 1);
            chk($sformatf("v%0d_tx_phases", v), r_bad, 0);
            chk($sformatf("v%0d_valid_dropped", v), res_valid_o, 0);
            if (v == 0) chk("min_latency", r_lat >= 7, 1);
        end

        // Result held back 10 cycles while the next op is offered
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 10, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
        chk("b2b_first_sum", r_s, 32'h0000_0030);
        chk("b2b_no_early_accept", r_leak, 0);
        run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 0, '0, '0, 1'b0);
        chk("b2b_second_sum", r_s, 32'h1010_1011);
        chk("b2b_second_cout", r_co, 0);

        // One A acknowledge held back 50 cycles
        dly_bit = 5; dly_n = 50;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, '0, '0, 1'b0);
        dly_bit = -1; dly_n = 0;
        chk("dly_hold_cycles", r_held >= 50, 1);
        chk("dly_no_premature_spacer", r_bad, 0);
        chk("dly_sum", r_s, 32'h0000_0100);

        // Reset pulse while TX is stuck in its data phase
        begin
            int n = 0;
            hold_c = 1;
            op_a_i = 32'h0000_1234; op_b_i = 32'h0000_0001; op_c_i = 1'b0; op_valid_i = 1'b1;
            while (!op_ready_o && n < 300) begin @(negedge clk); n++; end
            @(negedge clk);
            op_valid_i = 1'b0;
            repeat (8) @(negedge clk);
            chk("rst_pre_data", out_a, enc(32'h0000_1234));
            chk("rst_pre_ack_s", ack_s_o, 32'hFFFF_FFFF);
            rst = 1'b0;
            #1;
            chk("rst_out_a", out_a, 0);
            chk("rst_out_b", out_b, 0);
            chk("rst_out_c", out_c, 0);
            chk("rst_ack_s", ack_s_o, 0);
            chk("rst_ack_co", ack_co_o, 0);
            hold_c = 0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end
        run_op(32'h0000_1234, 32'h0000_0001, 1'b1, 0, '0, '0, 1'b0);
        chk("post_rst_timeout", r_to, 0);
        chk("post_rst_sum", r_s, 32'h0000_1236);
        chk("no_err_seen", err_o, 0);

`ifdef EL_HOST_TIMEOUT_EN
        begin
            int n = 0;
            bit saw_valid = 0;
            hold_c = 1;
            op_a_i = 32'h0000_0005; op_b_i = 32'h0000_0006; op_c_i = 1'b0; op_valid_i = 1'b1;
            while (!op_ready_o && n < 300) begin @(negedge clk); n++; end
            @(negedge clk);
            op_valid_i = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (res_valid_o) saw_valid = 1;
            end
            chk("tmo_err", err_o, 1);
            chk("tmo_out_a", out_a, 0);
            chk("tmo_out_c", out_c, 0);
            chk("tmo_ack_s", ack_s_o, 0);
            chk("tmo_no_result", saw_valid, 0);
            hold_c = 0;
            rst = 1'b0;
            #1 chk("tmo_err_cleared", err_o, 0);
            @(negedge clk);
            rst = 1'b1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
